// File: rtl/lm_sm_sequencer_pkg.sv
// lm_sm_sequencer_pkg: shared widths, FSM state and op encodings for the LM/SM sequencer.
package lm_sm_sequencer_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int IDX_W  = 3;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;
    typedef enum logic {
        OP_LM = 1'b0,
        OP_SM = 1'b1
    } op_e;
endpackage

// File: rtl/lm_sm_sequencer_lowbit_enc8.sv
// lowbit_enc8: combinational 8-to-3 lowest-set-bit priority encoder with valid flag.
module lowbit_enc8
    import lm_sm_sequencer_pkg::*;
(
    input  logic [NREGS-1:0] in_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);
    always_comb begin
        idx_o   = in_i[0] ? 3'd0 :
                  in_i[1] ? 3'd1 :
                  in_i[2] ? 3'd2 :
                  in_i[3] ? 3'd3 :
                  in_i[4] ? 3'd4 :
                  in_i[5] ? 3'd5 :
                  in_i[6] ? 3'd6 :
                  in_i[7] ? 3'd7 : 3'd0;
        valid_o = |in_i;
    end
endmodule

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: expands one LM/SM into one memory access per set mask bit at
// consecutive addresses, driving the data memory and register file directly.
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREGS-1:0]  reg_mask,
    input  logic [DATA_W-1:0] rf_read_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [IDX_W-1:0]  rf_read_sel,
    output logic              rf_write_en,
    output logic [IDX_W-1:0]  rf_write_sel,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_read,
    output logic              busy,
    output logic              done
);
    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NREGS-1:0]  mask_q, mask_d;
    logic [IDX_W-1:0]  idx;
    logic              idx_valid;
    logic              act, sm_act, lm_act;

    lowbit_enc8 u_enc (
        .in_i    (mask_q),
        .idx_o   (idx),
        .valid_o (idx_valid)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_LM;
            addr_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE: if (start) begin
                op_d    = op_e'(is_store);
                addr_d  = base_addr;
                mask_d  = reg_mask;
                state_d = |reg_mask ? S_RUN : S_DONE;
            end
            S_RUN: begin
                // clearing the lowest set bit retires the register just transferred
                mask_d  = mask_q & (mask_q - 1'b1);
                addr_d  = addr_q + 1'b1;
                state_d = |mask_d ? S_RUN : S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        act            = (state_q == S_RUN) && idx_valid;
        sm_act         = act && (op_q == OP_SM);
        lm_act         = act && (op_q == OP_LM);
        rf_read_sel    = act ? idx : '0;
        rf_write_sel   = act ? idx : '0;
        rf_write_en    = lm_act;
        rf_write_data  = lm_act ? mem_read_data : '0;
        mem_addr       = addr_q;
        mem_write_data = sm_act ? rf_read_data : '0;
        mem_write_read = sm_act;
        busy           = state_q != S_IDLE;
        done           = state_q == S_DONE;
    end
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: directed checks of the LM/SM sequencer against a small RF/memory model.
module tb_lm_sm_sequencer;
    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [15:0] base_addr = '0;
    logic [7:0]  reg_mask = '0;
    logic [15:0] rf_read_data, mem_read_data;
    logic [2:0]  rf_read_sel, rf_write_sel;
    logic        rf_write_en, mem_write_read, busy, done;
    logic [15:0] rf_write_data, mem_addr, mem_write_data;
    logic [15:0] rf [8];
    logic [15:0] mem [16];
    int          total = 0;
    int          bad = 0;

    lm_sm_sequencer dut (
        .clk            (clk),
        .Reset          (Reset),
        .start          (start),
        .is_store       (is_store),
        .base_addr      (base_addr),
        .reg_mask       (reg_mask),
        .rf_read_data   (rf_read_data),
        .mem_read_data  (mem_read_data),
        .rf_read_sel    (rf_read_sel),
        .rf_write_en    (rf_write_en),
        .rf_write_sel   (rf_write_sel),
        .rf_write_data  (rf_write_data),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write_read (mem_write_read),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    assign rf_read_data  = rf[rf_read_sel];
    assign mem_read_data = mem[mem_addr[3:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock: latch write intents at the negedge, commit them at the edge, settle 1ns
    task automatic cyc();
        logic        mw, rw;
        logic [3:0]  ma;
        logic [15:0] md, rd;
        logic [2:0]  rs;
        @(negedge clk);
        mw = mem_write_read; ma = mem_addr[3:0]; md = mem_write_data;
        rw = rf_write_en;    rs = rf_write_sel;  rd = rf_write_data;
        @(posedge clk);
        if (mw) mem[ma] = md;
        if (rw) rf[rs] = rd;
        #1;
    endtask

    task automatic io(input string tag, input logic [15:0] a, input logic wr, input logic we,
                      input logic b, input logic d);
        chk({tag, ".addr"}, mem_addr, a);
        chk({tag, ".wr"}, mem_write_read, wr);
        chk({tag, ".we"}, rf_write_en, we);
        chk({tag, ".busy"}, busy, b);
        chk({tag, ".done"}, done, d);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (2) cyc();
        io("rst", 16'h0, 0, 0, 0, 0);
        chk("rst.wdata", mem_write_data, 0);
        Reset = 1'b0;
        cyc();

        // SM base 4, mask 1000_0101
        rf[0] = 16'h1111; rf[2] = 16'h2222; rf[7] = 16'h7777;
        is_store = 1; base_addr = 16'h0004; reg_mask = 8'b1000_0101; start = 1;
        cyc(); start = 0;
        io("sm1", 16'h4, 1, 0, 1, 0); chk("sm1.rsel", rf_read_sel, 0); chk("sm1.wd", mem_write_data, 16'h1111);
        cyc();
        io("sm2", 16'h5, 1, 0, 1, 0); chk("sm2.rsel", rf_read_sel, 2); chk("sm2.wd", mem_write_data, 16'h2222);
        cyc();
        io("sm3", 16'h6, 1, 0, 1, 0); chk("sm3.rsel", rf_read_sel, 7); chk("sm3.wd", mem_write_data, 16'h7777);
        cyc();
        io("sm4", 16'h7, 0, 0, 1, 1); chk("sm4.wd", mem_write_data, 0);
        cyc();
        io("sm5", 16'h7, 0, 0, 0, 0);
        chk("sm.mem4", mem[4], 16'h1111); chk("sm.mem5", mem[5], 16'h2222); chk("sm.mem6", mem[6], 16'h7777);

        // LM base 10, all registers, wraps through mem index 15
        for (int i = 0; i < 8; i++) mem[(10 + i) % 16] = 16'h00A0 + 16'(i);
        is_store = 0; base_addr = 16'h000A; reg_mask = 8'hFF; start = 1;
        cyc(); start = 0;
        for (int k = 0; k < 8; k++) begin
            io($sformatf("lm%0d", k), 16'h000A + 16'(k), 0, 1, 1, 0);
            chk($sformatf("lm%0d.sel", k), rf_write_sel, k);
            chk($sformatf("lm%0d.data", k), rf_write_data, 16'h00A0 + 16'(k));
            cyc();
        end
        io("lm9", 16'h0012, 0, 0, 1, 1); chk("lm9.rd", rf_write_data, 0);
        cyc();
        for (int i = 0; i < 8; i++) chk($sformatf("lm.rf%0d", i), rf[i], 16'h00A0 + 16'(i));

        // zero mask, both ops
        for (int op = 0; op < 2; op++) begin
            is_store = op[0]; base_addr = 16'h0003; reg_mask = 8'h00; start = 1;
            cyc(); start = 0;
            io($sformatf("z%0d", op), 16'h3, 0, 0, 1, 1);
            cyc();
            io($sformatf("z%0d.idle", op), 16'h3, 0, 0, 0, 0);
        end

        // SM across the 16-bit address wrap
        is_store = 1; base_addr = 16'hFFFF; reg_mask = 8'b0000_0011; start = 1;
        cyc(); start = 0;
        io("wr1", 16'hFFFF, 1, 0, 1, 0);
        cyc();
        io("wr2", 16'h0000, 1, 0, 1, 0);
        cyc();
        io("wr3", 16'h0001, 0, 0, 1, 1);
        cyc();

        // start re-pulsed in RUN and DONE is ignored
        is_store = 1; base_addr = 16'h0000; reg_mask = 8'h0F; start = 1;
        cyc(); start = 0;
        for (int k = 0; k < 4; k++) begin
            io($sformatf("ign%0d", k), 16'(k), 1, 0, 1, 0);
            chk($sformatf("ign%0d.wd", k), mem_write_data, 16'h00A0 + 16'(k));
            start = (k == 1); reg_mask = 8'hF0; base_addr = 16'h0008;
            cyc();
        end
        io("ign.done", 16'h4, 0, 0, 1, 1);
        start = 1;
        cyc(); start = 0;
        io("ign.idle", 16'h4, 0, 0, 0, 0);
        cyc();
        io("ign.idle2", 16'h4, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("ign.mem%0d", i), mem[i], 16'h00A0 + 16'(i));

        // reset mid-RUN, with a simultaneous start
        is_store = 1; base_addr = 16'h0008; reg_mask = 8'hFF; start = 1;
        cyc(); start = 0;
        io("ra1", 16'h8, 1, 0, 1, 0);
        cyc();
        io("ra2", 16'h9, 1, 0, 1, 0);
        Reset = 1; start = 1; reg_mask = 8'h01;
        cyc();
        io("ra3", 16'h0, 0, 0, 0, 0);
        chk("ra3.rsel", rf_read_sel, 0); chk("ra3.wsel", rf_write_sel, 0);
        chk("ra3.wd", mem_write_data, 0); chk("ra3.rd", rf_write_data, 0);
        Reset = 0; start = 0;
        cyc();
        io("ra4", 16'h0, 0, 0, 0, 0);
        is_store = 0; base_addr = 16'h0003; reg_mask = 8'b0010_0000; start = 1;
        cyc(); start = 0;
        io("rb1", 16'h3, 0, 1, 1, 0);
        chk("rb1.sel", rf_write_sel, 5); chk("rb1.data", rf_write_data, 16'h00A3);
        cyc();
        io("rb2", 16'h4, 0, 0, 1, 1);
        cyc();
        io("rb3", 16'h4, 0, 0, 0, 0);
        chk("rb.rf5", rf[5], 16'h00A3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
